// File: rtl/mono_pack_pkg.sv
// Shared encodings and helpers for the mono pixel packer.
// Holds mode codes, FSM states, luma weights and the coordinate width.
package mono_pack_pkg;

  localparam int MONO_ADDR_W = 12;

  localparam int LUMA_W_R = 1;
  localparam int LUMA_W_G = 2;
  localparam int LUMA_W_B = 1;

  typedef enum logic [1:0] {
    MODE_LUMA_DITHER     = 2'b00,
    MODE_LUMA_THRESH     = 2'b01,
    MODE_BLUE_DITHER     = 2'b10,
    MODE_LUMA_DITHER_ALT = 2'b11
  } mono_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } mono_state_e;

  // (r + 2g + b) >> 2 computed on a 10-bit sum; maximum result is 255.
  function automatic logic [7:0] luma8(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
    logic [9:0] s;
    s = 10'(LUMA_W_R) * {2'b00, r} + 10'(LUMA_W_G) * {2'b00, g} + 10'(LUMA_W_B) * {2'b00, b};
    return 8'(s >> 2);
  endfunction

endpackage

// File: rtl/mono_noise_rom.sv
// Dither noise tile, 2^NOISE_BITS square, registered read (NOISE_BITS >= 4).
// The tile is an ordered (Bayer) threshold map generated from the address bits.
module mono_noise_rom #(
  parameter int NOISE_BITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2*NOISE_BITS-1:0] addr,
  output logic [7:0]              noise
);

  logic [NOISE_BITS-1:0]   ax;
  logic [NOISE_BITS-1:0]   ay;
  logic [2*NOISE_BITS-1:0] idx;
  logic [7:0]              top;
  logic [7:0]              noise_d;
  logic [7:0]              noise_q;

  // Highest coordinate bits land in the least significant index bits.
  // Values are capped at 254 so a black pixel never dithers to white.
  always_comb begin
    ax  = addr[2*NOISE_BITS-1:NOISE_BITS];
    ay  = addr[NOISE_BITS-1:0];
    idx = '0;
    for (int k = 0; k < NOISE_BITS; k++) begin
      idx[2*(NOISE_BITS-1-k)+1] = ax[k] ^ ay[k];
      idx[2*(NOISE_BITS-1-k)]   = ay[k];
    end
    top     = 8'(idx >> (2*NOISE_BITS-8));
    noise_d = (top == 8'hFF) ? 8'hFE : top;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) noise_q <= '0;
    else          noise_q <= noise_d;
  end

  assign noise = noise_q;

endmodule

// File: rtl/mono_pack_stream.sv
// Window crop, RGB->mono, MSB-first word packing and output FIFO.
// Optional MONO_PACK_DROP_CNT_EN adds a saturating dropped-word counter.
module mono_pack_stream
  import mono_pack_pkg::*;
#(
  parameter int WORD_BITS  = 16,
  parameter int NOISE_BITS = 6,
  parameter int X_OFFSET   = 64,
  parameter int Y_OFFSET   = 128,
  parameter int WIDTH      = 512,
  parameter int HEIGHT     = 342,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_sof,
  input  logic                   in_valid,
  input  logic [MONO_ADDR_W-1:0] in_x,
  input  logic [MONO_ADDR_W-1:0] in_y,
  input  logic [7:0]             in_r,
  input  logic [7:0]             in_g,
  input  logic [7:0]             in_b,
  input  logic [1:0]             mode,
  input  logic [7:0]             threshold,
  input  logic                   invert,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_BITS-1:0]   out_bits,
  output logic [MONO_ADDR_W-1:0] out_x,
  output logic [MONO_ADDR_W-1:0] out_y,
  output logic                   out_sof,
  output logic                   overflow,
`ifdef MONO_PACK_DROP_CNT_EN
  output logic [15:0]            drop_count,
`endif
  output mono_state_e            dbg_state
);

  localparam int CNT_W = $clog2(WORD_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int AW1   = MONO_ADDR_W + 1;
  localparam logic [AW1-1:0]         X_LO     = AW1'(X_OFFSET);
  localparam logic [AW1-1:0]         X_HI     = AW1'(X_OFFSET + WIDTH);
  localparam logic [AW1-1:0]         Y_LO     = AW1'(Y_OFFSET);
  localparam logic [AW1-1:0]         Y_HI     = AW1'(Y_OFFSET + HEIGHT);
  localparam logic [MONO_ADDR_W-1:0] X_OFF    = MONO_ADDR_W'(X_OFFSET);
  localparam logic [MONO_ADDR_W-1:0] Y_OFF    = MONO_ADDR_W'(Y_OFFSET);
  localparam logic [MONO_ADDR_W-1:0] LAST_X   = MONO_ADDR_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(WORD_BITS - 1);
  localparam logic [WORD_BITS-1:0]   TOP_BIT  = {1'b1, {(WORD_BITS-1){1'b0}}};
  localparam logic [OCC_W-1:0]       DEPTH_C  = OCC_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [WORD_BITS-1:0]   bits;
    logic [MONO_ADDR_W-1:0] x;
    logic [MONO_ADDR_W-1:0] y;
    logic                   sof;
  } word_t;

  // Output handshake: the FIFO head is offered while out_valid is high and
  // leaves the FIFO on any clock edge where out_valid and out_ready are both 1.

  mono_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (in_sof) state_d = ST_ACTIVE;
  end

  // Stage 0: window test and value selection on the raw input.
  mono_mode_e mode_e;
  logic       in_win;
  logic       accept;
  logic [7:0] px_val;

  always_comb begin
    mode_e = mono_mode_e'(mode);
    in_win = ({1'b0, in_x} >= X_LO) && ({1'b0, in_x} < X_HI) &&
             ({1'b0, in_y} >= Y_LO) && ({1'b0, in_y} < Y_HI);
    accept = (state_q == ST_ACTIVE) && in_valid && in_win;
    px_val = (mode_e == MODE_BLUE_DITHER) ? in_b : luma8(in_r, in_g, in_b);
  end

  logic [7:0] noise;

  mono_noise_rom #(.NOISE_BITS(NOISE_BITS)) u_noise (
    .clk    (clk),
    .reset_n(reset_n),
    .addr   ({in_x[NOISE_BITS-1:0], in_y[NOISE_BITS-1:0]}),
    .noise  (noise)
  );

  logic                   s1_valid_q, s1_thr_q, s1_inv_q, s1_last_q;
  logic [7:0]             s1_val_q, s1_threshold_q;
  logic [MONO_ADDR_W-1:0] s1_x_q, s1_y_q;
  logic [MONO_ADDR_W-1:0] s1_x_d;

  assign s1_x_d = in_x - X_OFF;

  // Stage 1: make the pixel bit and pack it into the accumulator.
  logic [WORD_BITS-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MONO_ADDR_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                   armed_q, armed_d;
  word_t                  wr_q, wr_d;
  logic                   wr_valid_q, wr_valid_d;

  logic [9:0]             dsum;
  logic                   pix_bit;
  logic                   word_done;
  logic [WORD_BITS-1:0]   word_bits;
  logic [MONO_ADDR_W-1:0] word_x, word_y;

  always_comb begin
    dsum      = {2'b00, s1_val_q} + {2'b00, noise} + 10'd1;
    pix_bit   = (s1_thr_q ? (s1_val_q >= s1_threshold_q) : (dsum >= 10'd256)) ^ s1_inv_q;
    word_bits = acc_q | (pix_bit ? (TOP_BIT >> cnt_q) : '0);
    word_x    = (cnt_q == '0) ? s1_x_q : acc_x_q;
    word_y    = (cnt_q == '0) ? s1_y_q : acc_y_q;
    word_done = (cnt_q == LAST_CNT) || s1_last_q;

    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    armed_d    = armed_q;
    wr_d       = wr_q;
    wr_valid_d = 1'b0;

    if (in_sof) begin
      acc_d   = '0;
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (s1_valid_q) begin
      if (word_done) begin
        wr_valid_d = 1'b1;
        wr_d.bits  = word_bits;
        wr_d.x     = word_x;
        wr_d.y     = word_y;
        wr_d.sof   = armed_q && (word_x == '0) && (word_y == '0);
        if (wr_d.sof) armed_d = 1'b0;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d   = word_bits;
        cnt_d   = cnt_q + 1'b1;
        acc_x_d = word_x;
        acc_y_d = word_y;
      end
    end
  end

  // Output FIFO; a completed word still in flight on in_sof is discarded.
  word_t            mem_q [FIFO_DEPTH];
  word_t            mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push_req, push, pop, full, drop;

  always_comb begin
    push_req = wr_valid_q && !in_sof;
    pop      = (count_q != '0) && out_ready;
    full     = (count_q == DEPTH_C);
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    mem_d = mem_q;
    if (push) mem_d[wptr_q] = wr_q;
    wptr_d     = wptr_q + PTR_W'(push);
    rptr_d     = rptr_q + PTR_W'(pop);
    count_d    = count_q + OCC_W'(push) - OCC_W'(pop);
    overflow_d = in_sof ? 1'b0 : (overflow_q || drop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      s1_valid_q     <= 1'b0;
      s1_thr_q       <= 1'b0;
      s1_inv_q       <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_val_q       <= '0;
      s1_threshold_q <= '0;
      s1_x_q         <= '0;
      s1_y_q         <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      acc_x_q        <= '0;
      acc_y_q        <= '0;
      armed_q        <= 1'b0;
      wr_q           <= '0;
      wr_valid_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_valid_q     <= accept;
      s1_thr_q       <= (mode_e == MODE_LUMA_THRESH);
      s1_inv_q       <= invert;
      s1_last_q      <= (s1_x_d == LAST_X);
      s1_val_q       <= px_val;
      s1_threshold_q <= threshold;
      s1_x_q         <= s1_x_d;
      s1_y_q         <= in_y - Y_OFF;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      acc_x_q        <= acc_x_d;
      acc_y_q        <= acc_y_d;
      armed_q        <= armed_d;
      wr_q           <= wr_d;
      wr_valid_q     <= wr_valid_d;
      mem_q          <= mem_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
    end
  end

`ifdef MONO_PACK_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_sof) drop_cnt_d = '0;
    else if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  word_t head;
  assign head      = mem_q[rptr_q];
  assign out_valid = (count_q != '0);
  assign out_bits  = head.bits;
  assign out_x     = head.x;
  assign out_y     = head.y;
  assign out_sof   = head.sof;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mono_pack_stream.sv
// Directed and randomized bench for mono_pack_stream against a pixel-level model.
// Builds with or without MONO_PACK_DROP_CNT_EN.
module tb_mono_pack_stream;
  import mono_pack_pkg::*;

  localparam int WB = 16;
  localparam int NB = 6;
  localparam int XO = 4;
  localparam int YO = 2;
  localparam int W  = 20;
  localparam int H  = 4;
  localparam int FD = 4;
  localparam int EW = WB + 25;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_sof, in_valid;
  logic [11:0]   in_x, in_y;
  logic [7:0]    in_r, in_g, in_b;
  logic [1:0]    mode;
  logic [7:0]    threshold;
  logic          invert;
  logic          out_valid, out_ready;
  logic [WB-1:0] out_bits;
  logic [11:0]   out_x, out_y;
  logic          out_sof, overflow;
  logic [15:0]   drop_count;
  mono_state_e   dbg_state;

  mono_pack_stream #(
    .WORD_BITS(WB), .NOISE_BITS(NB), .X_OFFSET(XO), .Y_OFFSET(YO),
    .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_sof(in_sof), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .mode(mode), .threshold(threshold), .invert(invert),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .overflow(overflow),
`ifdef MONO_PACK_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .dbg_state(dbg_state)
  );

`ifndef MONO_PACK_DROP_CNT_EN
  assign drop_count = 16'h0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int            bayer [64][64];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] obs_log [$];
  bit            mdl_active, mdl_armed, mdl_ovf;
  int            mdl_cnt, mdl_x, mdl_y, mdl_drops;
  logic [WB-1:0] mdl_word;

  task automatic build_bayer();
    int n;
    bayer[0][0] = 0;
    n = 1;
    while (n < 64) begin
      for (int y = 0; y < n; y++)
        for (int x = 0; x < n; x++) begin
          int v;
          v = bayer[y][x];
          bayer[y][x+n]   = 4*v + 2;
          bayer[y+n][x]   = 4*v + 3;
          bayer[y+n][x+n] = 4*v + 1;
          bayer[y][x]     = 4*v;
        end
      n = n * 2;
    end
  endtask

  function automatic bit mdl_bit(int x, int y, int r, int g, int b);
    int v, nz;
    bit bv;
    v  = (mode == 2'b10) ? b : (r + 2*g + b) / 4;
    nz = bayer[y % 64][x % 64] >> 4;
    if (nz > 254) nz = 254;
    if (mode == 2'b01) bv = (v >= int'(threshold));
    else               bv = ((v + nz + 1) >= 256);
    return bv ^ invert;
  endfunction

  task automatic mdl_reset();
    exp_q.delete();
    mdl_active = 0; mdl_armed = 0; mdl_ovf = 0;
    mdl_cnt = 0; mdl_word = '0; mdl_drops = 0;
  endtask

  task automatic mdl_pixel(int x, int y, int r, int g, int b, bit v);
    int wx, wy;
    logic [EW-1:0] e;
    bit s;
    if (!(mdl_active && v && x >= XO && x < XO+W && y >= YO && y < YO+H)) return;
    wx = x - XO; wy = y - YO;
    if (mdl_cnt == 0) begin mdl_x = wx; mdl_y = wy; mdl_word = '0; end
    mdl_word[WB-1-mdl_cnt] = mdl_bit(x, y, r, g, b);
    mdl_cnt++;
    if (mdl_cnt == WB || wx == W-1) begin
      s = mdl_armed && mdl_x == 0 && mdl_y == 0;
      if (s) mdl_armed = 0;
      e = {mdl_word, 12'(mdl_x), 12'(mdl_y), s};
      if (!out_ready && exp_q.size() >= FD) begin
        mdl_ovf = 1;
        mdl_drops++;
      end else exp_q.push_back(e);
      mdl_cnt = 0;
    end
  endtask

  function automatic logic [15:0] e_bits(logic [EW-1:0] e); return e[EW-1 -: WB]; endfunction
  function automatic logic [11:0] e_x(logic [EW-1:0] e);    return e[24:13];      endfunction
  function automatic logic [11:0] e_y(logic [EW-1:0] e);    return e[12:1];       endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      logic [EW-1:0] o;
      o = {out_bits, out_x, out_y, out_sof};
      obs_log.push_back(o);
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_word observed=%0h expected=none", o);
      end
      if (exp_q.size() != 0) chk("word", 64'(o), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic px(int x, int y, int r, int g, int b, bit v);
    in_valid = v; in_x = 12'(x); in_y = 12'(y);
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    mdl_pixel(x, y, r, g, b, v);
    cyc(1);
    in_valid = 0;
  endtask

  task automatic sof_pulse();
    cyc(3);
    in_sof = 1;
    mdl_active = 1; mdl_armed = 1; mdl_ovf = 0; mdl_drops = 0;
    mdl_cnt = 0; mdl_word = '0;
    cyc(1);
    in_sof = 0;
  endtask

  // kind: 0 white, 1 black, 2 alternating green, 3 random colour and strobe
  task automatic row(int y, int kind, int x_end);
    for (int x = 0; x < x_end; x++) begin
      int r, g, b;
      bit v;
      v = 1;
      case (kind)
        0:       begin r = 255; g = 255; b = 255; end
        1:       begin r = 0; g = 0; b = 0; end
        2:       begin r = 255; b = 255; g = (((x - XO) % 2) == 0) ? 255 : 0; end
        default: begin
          r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
          v = ($urandom_range(0, 3) != 0);
        end
      endcase
      px(x, y, r, g, b, v);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    cyc(3);
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin cyc(1); t++; end
    chk("drain_timeout", 64'(t < 200), 64'd1);
  endtask

  task automatic chk_log(string tag, int i, logic [15:0] bits, int x, int y, bit s);
    chk({tag, "_present"}, 64'(obs_log.size() > i), 64'd1);
    if (obs_log.size() > i) begin
      chk({tag, "_bits"}, 64'(e_bits(obs_log[i])), 64'(bits));
      chk({tag, "_x"}, 64'(e_x(obs_log[i])), 64'(x));
      chk({tag, "_y"}, 64'(e_y(obs_log[i])), 64'(y));
      chk({tag, "_sof"}, 64'(obs_log[i][0]), 64'(s));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    build_bayer();
    mdl_reset();
    reset_n = 0; in_sof = 0; in_valid = 0; in_x = 0; in_y = 0;
    in_r = 0; in_g = 0; in_b = 0; mode = 0; threshold = 0; invert = 0; out_ready = 1;
    cyc(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_bits", 64'(out_bits), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    reset_n = 1;
    cyc(2);

    // pixels before the first sof are ignored
    row(2, 0, 28);
    cyc(5);
    chk("idle_no_words", 64'(out_valid), 64'd0);
    chk("idle_state", 64'(dbg_state), 64'(ST_IDLE));

    // threshold mode, alternating row
    sof_pulse();
    chk("active_state", 64'(dbg_state), 64'(ST_ACTIVE));
    mode = 2'b01; threshold = 8'h80; invert = 0;
    obs_log.delete();
    row(2, 2, 28);
    wait_drain();
    chk_log("alt0", 0, 16'hAAAA, 0, 0, 1);
    chk_log("alt1", 1, 16'hA000, 16, 0, 0);

    // short final word of a row is zero padded
    obs_log.delete();
    row(3, 0, 28);
    wait_drain();
    chk_log("white0", 0, 16'hFFFF, 0, 1, 0);
    chk_log("white1", 1, 16'hF000, 16, 1, 0);

    // dither extremes and invert
    mode = 2'b00;
    obs_log.delete();
    row(4, 0, 28);
    row(5, 1, 28);
    wait_drain();
    chk_log("dw0", 0, 16'hFFFF, 0, 2, 0);
    chk_log("dw1", 1, 16'hF000, 16, 2, 0);
    chk_log("db0", 2, 16'h0000, 0, 3, 0);
    chk_log("db1", 3, 16'h0000, 16, 3, 0);
    invert = 1;
    sof_pulse();
    obs_log.delete();
    row(2, 0, 28);
    row(3, 1, 28);
    wait_drain();
    chk_log("iw0", 0, 16'h0000, 0, 0, 1);
    chk_log("iw1", 1, 16'h0000, 16, 0, 0);
    chk_log("ib0", 2, 16'hFFFF, 0, 1, 0);
    chk_log("ib1", 3, 16'hF000, 16, 1, 0);

    // randomized frames against the model
    for (int f = 0; f < 3; f++) begin
      sof_pulse();
      for (int y = 0; y < 8; y++) begin
        mode      = 2'($urandom_range(0, 3));
        threshold = 8'($urandom_range(0, 255));
        invert    = 1'($urandom_range(0, 1));
        row(y, 3, 28);
      end
    end
    wait_drain();

    // sof discards a partial word
    mode = 2'b01; threshold = 8'h80; invert = 0;
    sof_pulse();
    for (int x = XO; x < XO + 7; x++) px(x, YO, 255, 255, 255, 1);
    sof_pulse();
    obs_log.delete();
    row(2, 0, 28);
    wait_drain();
    chk("partial_count", 64'(obs_log.size()), 64'd2);
    chk_log("after_sof", 0, 16'hFFFF, 0, 0, 1);

    // full FIFO drops the fifth word
    out_ready = 0;
    obs_log.delete();
    row(3, 0, 28);
    row(4, 0, 28);
    row(5, 0, XO + 16);
    cyc(4);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    chk("hold_overflow", 64'(overflow), 64'(mdl_ovf));
    chk("hold_overflow_set", 64'(overflow), 64'd1);
`ifdef MONO_PACK_DROP_CNT_EN
    chk("hold_drop_count", 64'(drop_count), 64'(mdl_drops));
`endif
    out_ready = 1;
    wait_drain();
    chk("hold_words", 64'(obs_log.size()), 64'd4);
    chk("overflow_sticky", 64'(overflow), 64'd1);
    sof_pulse();
    chk("overflow_cleared", 64'(overflow), 64'd0);
`ifdef MONO_PACK_DROP_CNT_EN
    chk("drop_count_cleared", 64'(drop_count), 64'd0);
`endif

    // reset mid-frame with a full FIFO
    out_ready = 0;
    row(2, 0, 28);
    row(3, 0, 28);
    row(4, 0, 28);
    cyc(3);
    chk("pre_reset_overflow", 64'(overflow), 64'd1);
    reset_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    mdl_reset();
    cyc(1);
    reset_n = 1;
    out_ready = 1;
    obs_log.delete();
    row(2, 0, 28);
    cyc(5);
    chk("post_reset_no_words", 64'(out_valid), 64'd0);
    chk("post_reset_log", 64'(obs_log.size()), 64'd0);
    sof_pulse();
    row(2, 0, 28);
    wait_drain();
    chk_log("post_reset", 0, 16'hFFFF, 0, 0, 1);

    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
